// File: rtl/dec_stage.sv
// Instruction decode stage: splits IR fields and registers the control word.
// Define DEC_SCOREBOARD_EN to build the RAW/WAW register scoreboard.
module dec_stage #(
  parameter int IR_W = 32,
  parameter int OP_W = 7,
  parameter int RA_W = 5,
  localparam int IMM_W = IR_W - OP_W - 3 * RA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IR_W-1:0]  in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA_W-1:0]  out_da,
  output logic [RA_W-1:0]  out_aa,
  output logic [RA_W-1:0]  out_ba,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_rw,
  output logic [1:0]       out_md,
  output logic [1:0]       out_bs,
  output logic             out_ps,
  output logic             out_mw,
  output logic [4:0]       out_fs,
  output logic             out_ma,
  output logic             out_mb,
  output logic             out_cs,
  output logic             out_ill,
  input  logic             wb_valid,
  input  logic [RA_W-1:0]  wb_addr
);

  localparam int NREG = 1 << RA_W;
  localparam int OPX  = (OP_W > 7) ? OP_W : 8;

  typedef struct packed {
    logic [RA_W-1:0]  da;
    logic [RA_W-1:0]  aa;
    logic [RA_W-1:0]  ba;
    logic [IMM_W-1:0] imm;
    logic             rw;
    logic [1:0]       md;
    logic [1:0]       bs;
    logic             ps;
    logic             mw;
    logic [4:0]       fs;
    logic             ma;
    logic             mb;
    logic             cs;
    logic             ill;
  } word_t;

  logic [OP_W-1:0]  op;
  logic [RA_W-1:0]  da, aa, ba;
  logic [IMM_W-1:0] imm;
  logic [OPX-1:0]   op_x;
  logic [6:0]       op7;
  logic             hi_ok;

  assign op    = in_ir[IR_W-1 -: OP_W];
  assign da    = in_ir[IR_W-OP_W-1 -: RA_W];
  assign aa    = in_ir[IR_W-OP_W-RA_W-1 -: RA_W];
  assign ba    = in_ir[IR_W-OP_W-2*RA_W-1 -: RA_W];
  assign imm   = in_ir[IMM_W-1:0];
  assign op_x  = OPX'(op);
  assign op7   = op_x[6:0];
  assign hi_ok = (op_x[OPX-1:7] == '0);

  logic       d_rw, d_ps, d_mw, d_ma, d_mb, d_cs, d_ill;
  logic [1:0] d_md, d_bs;
  logic [4:0] d_fs;
  logic       d_ra, d_rb;

  always_comb begin
    d_rw  = 1'b0;
    d_md  = 2'd0;
    d_bs  = 2'd0;
    d_ps  = 1'b0;
    d_mw  = 1'b0;
    d_fs  = 5'd0;
    d_ma  = 1'b0;
    d_mb  = 1'b0;
    d_cs  = 1'b0;
    d_ill = 1'b0;
    if (!hi_ok) begin
      d_ill = 1'b1;
    end else begin
      unique case (op7)
        7'h00: ;
        7'h02: begin d_rw = 1'b1; d_fs = 5'd2;  end
        7'h05: begin d_rw = 1'b1; d_fs = 5'd5;  end
        7'h10: begin d_rw = 1'b1; d_fs = 5'd8;  end
        7'h0A: begin d_rw = 1'b1; d_fs = 5'd10; end
        7'h0C: begin d_rw = 1'b1; d_fs = 5'd12; end
        7'h65: begin
          d_rw = 1'b1; d_md = 2'd2; d_fs = 5'd5;
        end
        7'h01: d_mw = 1'b1;
        7'h21: begin d_rw = 1'b1; d_md = 2'd1; end
        7'h40: d_rw = 1'b1;
        7'h30: begin d_rw = 1'b1; d_fs = 5'd20; end
        7'h31: begin d_rw = 1'b1; d_fs = 5'd24; end
        7'h2E: begin d_rw = 1'b1; d_fs = 5'd14; end
        7'h22: begin
          d_rw = 1'b1; d_mb = 1'b1; d_cs = 1'b1; d_fs = 5'd2;
        end
        7'h25: begin
          d_rw = 1'b1; d_mb = 1'b1; d_cs = 1'b1; d_fs = 5'd5;
        end
        7'h28: begin d_rw = 1'b1; d_mb = 1'b1; d_fs = 5'd8;  end
        7'h2A: begin d_rw = 1'b1; d_mb = 1'b1; d_fs = 5'd10; end
        7'h2C: begin d_rw = 1'b1; d_mb = 1'b1; d_fs = 5'd12; end
        7'h62: begin d_rw = 1'b1; d_mb = 1'b1; d_fs = 5'd2;  end
        7'h45: begin d_rw = 1'b1; d_mb = 1'b1; d_fs = 5'd5;  end
        7'h20: begin d_bs = 2'd1; d_mb = 1'b1; d_cs = 1'b1; end
        7'h60: begin
          d_bs = 2'd1; d_ps = 1'b1; d_mb = 1'b1; d_cs = 1'b1;
        end
        7'h61: d_bs = 2'd2;
        7'h07: begin d_bs = 2'd3; d_mb = 1'b1; d_cs = 1'b1; end
        7'h27: begin
          d_rw = 1'b1; d_bs = 2'd3; d_fs = 5'd7;
          d_ma = 1'b1; d_mb = 1'b1; d_cs = 1'b1;
        end
        default: d_ill = 1'b1;
      endcase
    end
    d_ra = !d_ill && !(op7 inside {7'h00, 7'h07, 7'h27});
    d_rb = !d_ill &&
      (op7 inside {7'h02, 7'h05, 7'h65, 7'h10, 7'h0A, 7'h0C, 7'h01});
  end

  word_t dec;
  assign dec = '{da: da, aa: aa, ba: ba, imm: imm,
                 rw: d_rw, md: d_md, bs: d_bs, ps: d_ps,
                 mw: d_mw, fs: d_fs, ma: d_ma, mb: d_mb,
                 cs: d_cs, ill: d_ill};

  logic  hazard, in_fire;
  logic  valid_q, valid_d;
  word_t word_q, word_d;

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign in_fire  = in_valid && in_ready;

`ifdef DEC_SCOREBOARD_EN
  logic [NREG-1:0] pend_q, pend_d;

  // Hazards look only at the registered bits; writebacks are not bypassed.
  assign hazard = in_valid &&
    ((d_ra && pend_q[aa]) || (d_rb && pend_q[ba]) || (d_rw && pend_q[da]));

  always_comb begin
    pend_d = pend_q;
    if (wb_valid) pend_d[wb_addr] = 1'b0;
    if (in_fire && d_rw) pend_d[da] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr, d_ra, d_rb, NREG[0]};
  assign hazard    = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (in_fire) begin
      valid_d = 1'b1;
      word_d  = dec;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign out_valid = valid_q;
  assign out_da    = word_q.da;
  assign out_aa    = word_q.aa;
  assign out_ba    = word_q.ba;
  assign out_imm   = word_q.imm;
  assign out_rw    = word_q.rw;
  assign out_md    = word_q.md;
  assign out_bs    = word_q.bs;
  assign out_ps    = word_q.ps;
  assign out_mw    = word_q.mw;
  assign out_fs    = word_q.fs;
  assign out_ma    = word_q.ma;
  assign out_mb    = word_q.mb;
  assign out_cs    = word_q.cs;
  assign out_ill   = word_q.ill;

endmodule
